// File: rtl/l2_vector_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | l2_vector_packer: packs 16-bit stream elements four-per-beat into a      |
// | zero-padded 64-bit AXI-Stream. Optional length limit: L2_PACK_MAXLEN_EN. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module l2_vector_packer #(
  parameter int MAX_ELEMS = 1024
) (
  input  logic        clock,
  input  logic        rstn,
  input  logic [15:0] io_in_tdata,
  input  logic        io_in_tvalid,
  output logic        io_in_tready,
  input  logic        io_in_tlast,
  output logic [63:0] io_out_tdata,
  output logic        io_out_tvalid,
  input  logic        io_out_tready,
  output logic [7:0]  io_out_tkeep,
  output logic        io_out_tuser,
  output logic        io_out_tlast,
  output logic        io_err
);

  logic [2:0][15:0] asm_q, asm_d;
  logic [1:0]       lane_q, lane_d;
  logic             first_q, first_d;
  logic [63:0]      data_q, data_d;
  logic [7:0]       keep_q, keep_d;
  logic             user_q, user_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  logic             in_fire;
  logic             accept_elem;
  logic             beat_last;
  logic             beat_complete;
  logic [63:0]      beat_data;
  logic [7:0]       beat_keep;

  assign io_in_tready = !valid_q || io_out_tready;
  assign in_fire      = io_in_tvalid && io_in_tready;

`ifdef L2_PACK_MAXLEN_EN
  localparam logic [15:0] MAX_C = 16'(MAX_ELEMS);

  logic [15:0] elem_cnt_q, elem_cnt_d;
  logic        drop_q, drop_d;
  logic        err_q, err_d;
  logic        cnt_hit;

  // Elements arriving after a forced truncation are swallowed until the tlast.
  assign accept_elem = in_fire && !drop_q;
  assign cnt_hit     = (elem_cnt_q + 16'd1) == MAX_C;
  assign beat_last   = io_in_tlast || cnt_hit;
  assign io_err      = err_q;

  always_comb begin
    elem_cnt_d = elem_cnt_q;
    drop_d     = drop_q;
    err_d      = err_q;
    if (accept_elem) begin
      elem_cnt_d = beat_last ? 16'd0 : elem_cnt_q + 16'd1;
      if (cnt_hit && !io_in_tlast) begin
        drop_d = 1'b1;
        err_d  = 1'b1;
      end
    end
    if (in_fire && drop_q && io_in_tlast) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      elem_cnt_q <= 16'd0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      elem_cnt_q <= elem_cnt_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = |MAX_ELEMS;
  assign accept_elem = in_fire;
  assign beat_last   = io_in_tlast;
  assign io_err      = 1'b0;
`endif

  assign beat_complete = (lane_q == 2'd3) || beat_last;

  // Lanes above the incoming element are forced to zero so they add nothing downstream.
  always_comb begin
    beat_data = 64'd0;
    beat_keep = 8'h00;
    case (lane_q)
      2'd0: begin
        beat_data = {48'd0, io_in_tdata};
        beat_keep = 8'h03;
      end
      2'd1: begin
        beat_data = {32'd0, io_in_tdata, asm_q[0]};
        beat_keep = 8'h0F;
      end
      2'd2: begin
        beat_data = {16'd0, io_in_tdata, asm_q[1], asm_q[0]};
        beat_keep = 8'h3F;
      end
      default: begin
        beat_data = {io_in_tdata, asm_q[2], asm_q[1], asm_q[0]};
        beat_keep = 8'hFF;
      end
    endcase
  end

  always_comb begin
    asm_d   = asm_q;
    lane_d  = lane_q;
    first_d = first_q;
    data_d  = data_q;
    keep_d  = keep_q;
    user_d  = user_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (valid_q && io_out_tready) begin
      valid_d = 1'b0;
    end
    if (accept_elem) begin
      if (!beat_complete) begin
        case (lane_q)
          2'd0:    asm_d[0] = io_in_tdata;
          2'd1:    asm_d[1] = io_in_tdata;
          default: asm_d[2] = io_in_tdata;
        endcase
        lane_d = lane_q + 2'd1;
      end else begin
        // A load overrides the drain above, giving back-to-back beats.
        data_d  = beat_data;
        keep_d  = beat_keep;
        user_d  = first_q;
        last_d  = beat_last;
        valid_d = 1'b1;
        lane_d  = 2'd0;
        first_d = beat_last;
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      asm_q   <= '0;
      lane_q  <= 2'd0;
      first_q <= 1'b1;
      data_q  <= 64'd0;
      keep_q  <= 8'h00;
      user_q  <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      lane_q  <= lane_d;
      first_q <= first_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      user_q  <= user_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign io_out_tdata  = data_q;
  assign io_out_tkeep  = keep_q;
  assign io_out_tuser  = user_q;
  assign io_out_tlast  = last_q;
  assign io_out_tvalid = valid_q;

endmodule
`default_nettype wire
